// File: rtl/pi_spi_bridge.sv
// pi_spi_bridge: SPI mode-0 slave turning RPi frames into 17-bit bus writes/reads.
// Ports: clk, reset; spi_sclk/cs_n/mosi in, spi_miso out; pi_addr, pi_data_out,
//        pi_data_in, pi_write_strobe, pi_read_strobe, overrun (sticky error).
module pi_spi_bridge #(
  parameter int STROBE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [16:0] pi_addr,
  output logic [7:0]  pi_data_out,
  input  logic [7:0]  pi_data_in,
  output logic        pi_write_strobe,
  output logic        pi_read_strobe,
  output logic        overrun
);

  localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_IGNORE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  state_t      state_q, state_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [2:0]  bit_q, bit_d;
  logic        rd_frame_q, rd_frame_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        pend_wr_q, pend_wr_d;
  logic        pend_rd_q, pend_rd_d;
  logic        wr_stb_q, wr_stb_d;
  logic        rd_stb_q, rd_stb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        inc_q, inc_d;
  logic        ovr_q, ovr_d;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall;
  logic       busy;
  logic [7:0] rx_byte;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign rx_byte   = {rx_q[6:0], mosi_s};
  // Any access still in flight, up to and including its address step.
  assign busy = pend_wr_q | pend_rd_q | wr_stb_q | rd_stb_q | inc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rx_q       <= '0;
      tx_q       <= '0;
      bit_q      <= '0;
      rd_frame_q <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      pend_wr_q  <= 1'b0;
      pend_rd_q  <= 1'b0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      cnt_q      <= '0;
      inc_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      bit_q      <= bit_d;
      rd_frame_q <= rd_frame_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      cnt_q      <= cnt_d;
      inc_q      <= inc_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    bit_d      = bit_q;
    rd_frame_d = rd_frame_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    pend_wr_d  = 1'b0;
    pend_rd_d  = 1'b0;
    wr_stb_d   = wr_stb_q;
    rd_stb_d   = rd_stb_q;
    cnt_d      = cnt_q;
    inc_d      = 1'b0;
    ovr_d      = ovr_q;

    // Strobe engine: one idle clk of setup, STROBE_CYCLES high,
    // then one clk of hold before the address steps.
    if (pend_wr_q) begin
      wr_stb_d = 1'b1;
      cnt_d    = CNT_LOAD;
    end else if (pend_rd_q) begin
      rd_stb_d = 1'b1;
      cnt_d    = CNT_LOAD;
    end else if (wr_stb_q || rd_stb_q) begin
      if (cnt_q == '0) begin
        wr_stb_d = 1'b0;
        rd_stb_d = 1'b0;
        inc_d    = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    if (inc_q) addr_d = addr_q + 17'd1;

    // The falling edge after a byte's 8th rise is skipped so a
    // late read load is not shifted away before the next byte.
    if (sclk_fall && !cs_s && bit_q != 3'd0)
      tx_d = {tx_q[6:0], 1'b0};
    if (rd_stb_q && cnt_q == '0)
      tx_d = pi_data_in;

    if (cs_s) begin
      state_d = S_IDLE;
      bit_d   = '0;
      rx_d    = '0;
    end else if (cs_fall) begin
      state_d = S_CMD;
      bit_d   = '0;
      rx_d    = '0;
      ovr_d   = 1'b0;
    end else if (sclk_rise && state_q != S_IDLE) begin
      rx_d  = rx_byte;
      bit_d = bit_q + 3'd1;
      if (bit_q == 3'd7) begin
        if (busy) begin
          ovr_d = 1'b1;
        end else begin
          unique case (state_q)
            S_CMD: begin
              if (rx_byte[7]) begin
                rd_frame_d = rx_byte[6];
                addr_d[16] = rx_byte[0];
                state_d    = S_ADDR_HI;
              end else begin
                state_d = S_IGNORE;
              end
            end
            S_ADDR_HI: begin
              addr_d[15:8] = rx_byte;
              state_d      = S_ADDR_LO;
            end
            S_ADDR_LO: begin
              addr_d[7:0] = rx_byte;
              state_d     = S_DATA;
              pend_rd_d   = rd_frame_q;
            end
            S_DATA: begin
              if (rd_frame_q) begin
                pend_rd_d = 1'b1;
              end else begin
                dout_d    = rx_byte;
                pend_wr_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign spi_miso        = tx_q[7] & ~cs_s;
  assign pi_addr         = addr_q;
  assign pi_data_out     = dout_q;
  assign pi_write_strobe = wr_stb_q;
  assign pi_read_strobe  = rd_stb_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_pi_spi_bridge.sv
// tb_pi_spi_bridge: directed + random frames against a transaction-level model.
// A monitor checks every strobe pulse, its timing and the address step.
module tb_pi_spi_bridge;

  typedef struct packed {
    logic        wr;
    logic [16:0] a;
    logic [7:0]  d;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [16:0] pi_addr;
  logic [7:0]  pi_data_out;
  logic [7:0]  pi_data_in;
  logic        pi_write_strobe;
  logic        pi_read_strobe;
  logic        overrun;

  logic        ovr_miso;
  logic [16:0] ovr_addr;
  logic [7:0]  ovr_dout;
  logic [7:0]  ovr_din = 8'h00;
  logic        ovr_wr;
  logic        ovr_rd;
  logic        ovr_overrun;

  int n_cmp = 0;
  int n_err = 0;

  acc_t        exp_q[$];
  acc_t        log_q[$];
  logic [7:0]  fb[$];
  logic [7:0]  rxq[$];
  logic [7:0]  exp_miso[$];
  logic [16:0] exp_addr = '0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rdf(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5F;
  endfunction

  function automatic acc_t mk(input logic w, input logic [16:0] a,
                              input logic [7:0] d);
    acc_t e;
    e.wr = w;
    e.a  = a;
    e.d  = d;
    return e;
  endfunction

  assign pi_data_in = rdf(pi_addr);

  pi_spi_bridge dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .pi_addr(pi_addr), .pi_data_out(pi_data_out),
    .pi_data_in(pi_data_in),
    .pi_write_strobe(pi_write_strobe),
    .pi_read_strobe(pi_read_strobe),
    .overrun(overrun)
  );

  pi_spi_bridge #(.STROBE_CYCLES(100), .SYNC_STAGES(2)) u_ovr (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(ovr_miso),
    .pi_addr(ovr_addr), .pi_data_out(ovr_dout),
    .pi_data_in(ovr_din),
    .pi_write_strobe(ovr_wr),
    .pi_read_strobe(ovr_rd),
    .overrun(ovr_overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every strobe rise is matched to the model queue.
  logic        pw = 1'b0, pr = 1'b0;
  int          width = 0;
  int          post = 0;
  logic [16:0] hold_a = '0, last_a = '0;
  logic [7:0]  hold_d = '0, last_d = '0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      pw = 1'b0;
      pr = 1'b0;
      post = 0;
      width = 0;
    end else begin
      if (pi_write_strobe && pi_read_strobe)
        chk("strobe_excl", 32'd1, 32'd0);
      if ((pi_write_strobe && !pw) || (pi_read_strobe && !pr)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {15'd0, pi_addr}, 32'hFFFFFFFF);
        end else begin
          acc_t e;
          e = exp_q.pop_front();
          chk("acc_type", {31'd0, pi_write_strobe}, {31'd0, e.wr});
          chk("acc_addr", {15'd0, pi_addr}, {15'd0, e.a});
          if (pi_write_strobe)
            chk("acc_data", {24'd0, pi_data_out}, {24'd0, e.d});
        end
        chk("addr_setup", {15'd0, pi_addr}, {15'd0, last_a});
        if (pi_write_strobe)
          chk("data_setup", {24'd0, pi_data_out}, {24'd0, last_d});
        chk("overrun_quiet", {31'd0, overrun}, 32'd0);
        log_q.push_back(mk(pi_write_strobe, pi_addr,
                           pi_write_strobe ? pi_data_out : 8'h00));
        hold_a = pi_addr;
        hold_d = pi_data_out;
        width = 1;
      end else if (pi_write_strobe || pi_read_strobe) begin
        width++;
        chk("addr_hold", {15'd0, pi_addr}, {15'd0, hold_a});
        if (pi_write_strobe)
          chk("data_hold", {24'd0, pi_data_out}, {24'd0, hold_d});
      end
      if ((pw && !pi_write_strobe) || (pr && !pi_read_strobe)) begin
        chk("strobe_width", width, 4);
        chk("addr_after_fall", {15'd0, pi_addr}, {15'd0, hold_a});
        post = 1;
      end else if (post == 1) begin
        chk("addr_inc", {15'd0, pi_addr}, {15'd0, hold_a + 17'd1});
        post = 0;
      end
      pw = pi_write_strobe;
      pr = pi_read_strobe;
    end
    last_a = pi_addr;
    last_d = pi_data_out;
  end

  int   ovr_cnt = 0;
  logic ovr_pw = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!reset && ovr_wr && !ovr_pw) ovr_cnt++;
    ovr_pw = ovr_wr;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits,
                      input int h, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      clks(h);
      spi_sclk = 1'b1;
      rx[i] = spi_miso;
      clks(h);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int extra, input int h, input int gap);
    logic [7:0] r;
    rxq.delete();
    spi_cs_n = 1'b0;
    clks(4);
    foreach (fb[i]) begin
      xfer(fb[i], 8, h, r);
      rxq.push_back(r);
      clks(gap);
    end
    if (extra > 0) begin
      xfer(8'hA6, extra, h, r);
      clks(gap);
    end
    spi_cs_n = 1'b1;
    clks(2);
  endtask

  // Frame-level model: which accesses a frame of whole bytes causes.
  task automatic model_frame();
    logic [16:0] cur;
    logic        rd;
    exp_miso.delete();
    if (fb.size() == 0) return;
    if (!fb[0][7]) return;
    rd = fb[0][6];
    exp_addr[16] = fb[0][0];
    if (fb.size() >= 2) exp_addr[15:8] = fb[1];
    if (fb.size() < 3) return;
    exp_addr[7:0] = fb[2];
    cur = exp_addr;
    if (rd) begin
      exp_q.push_back(mk(1'b0, cur, 8'h00));
      cur = cur + 17'd1;
    end
    for (int k = 3; k < fb.size(); k++) begin
      if (rd) begin
        exp_miso.push_back(rdf(cur - 17'd1));
        exp_q.push_back(mk(1'b0, cur, 8'h00));
      end else begin
        exp_q.push_back(mk(1'b1, cur, fb[k]));
      end
      cur = cur + 17'd1;
    end
    exp_addr = cur;
  endtask

  task automatic check_frame();
    chk("model_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("addr_end", {15'd0, pi_addr}, {15'd0, exp_addr});
    foreach (exp_miso[k])
      chk("miso_byte", {24'd0, rxq[3+k]}, {24'd0, exp_miso[k]});
    chk("overrun_end", {31'd0, overrun}, 32'd0);
  endtask

  task automatic do_frame(input int extra, input int h, input int gap);
    log_q.delete();
    model_frame();
    run_frame(extra, h, gap);
    clks(20);
    check_frame();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r;
    int seen;
    int c0;

    clks(3);
    chk("rst_wr", {31'd0, pi_write_strobe}, 32'd0);
    chk("rst_rd", {31'd0, pi_read_strobe}, 32'd0);
    chk("rst_addr", {15'd0, pi_addr}, 32'd0);
    chk("rst_dout", {24'd0, pi_data_out}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    reset = 1'b0;
    clks(4);

    fb = '{8'h80, 8'hE8, 8'h03, 8'h5A};
    do_frame(0, 5, 2);
    chk("w1_count", log_q.size(), 1);
    chk("w1_acc", log_q[0], mk(1'b1, 17'h0E803, 8'h5A));
    chk("w1_addr", {15'd0, pi_addr}, 32'h0E804);

    // Reset while a write strobe is high.
    fb = '{8'h80, 8'h12, 8'h34, 8'h77};
    model_frame();
    spi_cs_n = 1'b0;
    clks(4);
    for (int i = 0; i < 3; i++) begin
      xfer(fb[i], 8, 4, r);
      clks(2);
    end
    xfer(fb[3], 8, 4, r);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (pi_write_strobe) seen = 1;
      else clks(1);
    end
    chk("rst_mid_seen", seen, 1);
    reset = 1'b1;
    #1;
    chk("rstm_wr", {31'd0, pi_write_strobe}, 32'd0);
    chk("rstm_addr", {15'd0, pi_addr}, 32'd0);
    chk("rstm_dout", {24'd0, pi_data_out}, 32'd0);
    chk("rstm_ovr", {31'd0, overrun}, 32'd0);
    chk("rstm_miso", {31'd0, spi_miso}, 32'd0);
    exp_q.delete();
    exp_addr = '0;
    spi_cs_n = 1'b1;
    clks(4);
    reset = 1'b0;
    clks(4);

    fb = '{8'h80, 8'hE8, 8'h00};
    for (int i = 0; i < 10; i++) fb.push_back(8'(i));
    do_frame(0, 4, 2);
    chk("burst_count", log_q.size(), 10);
    for (int i = 0; i < 10 && i < log_q.size(); i++)
      chk("burst_acc", log_q[i],
          mk(1'b1, 17'h0E800 + 17'(i), 8'(i)));
    chk("burst_addr", {15'd0, pi_addr}, 32'h0E80A);

    fb = '{8'hC0, 8'hE8, 8'h12, 8'h00};
    do_frame(0, 6, 3);
    chk("rd_miso", {24'd0, rxq[3]}, 32'hA5);
    chk("rd_acc", log_q[0], mk(1'b0, 17'h0E812, 8'h00));

    fb = '{8'h81, 8'hFF, 8'hFF, 8'h11, 8'h22};
    do_frame(0, 4, 2);
    chk("wrap_0", log_q[0], mk(1'b1, 17'h1FFFF, 8'h11));
    chk("wrap_1", log_q[1], mk(1'b1, 17'h00000, 8'h22));
    chk("wrap_addr", {15'd0, pi_addr}, 32'h00001);

    fb = '{8'h80, 8'hE8};
    do_frame(5, 5, 2);
    chk("abort_none", log_q.size(), 0);

    // Second instance with a long strobe makes an overrun reachable.
    clks(150);
    fb = '{8'h80, 8'h00, 8'h10, 8'hAA, 8'hBB};
    c0 = ovr_cnt;
    do_frame(0, 4, 2);
    chk("ovr_set", {31'd0, ovr_overrun}, 32'd1);
    chk("ovr_one_write", ovr_cnt - c0, 1);
    clks(150);
    chk("ovr_sticky", {31'd0, ovr_overrun}, 32'd1);

    fb = '{8'h00, 8'hE8, 8'h00, 8'h55};
    do_frame(0, 5, 2);
    chk("cmd0_none", log_q.size(), 0);
    chk("ovr_cleared", {31'd0, ovr_overrun}, 32'd0);

    for (int f = 0; f < 40; f++) begin
      int kind, nd, n, extra;
      logic rd;
      logic [16:0] a;
      logic [7:0] c;
      fb.delete();
      kind = $urandom_range(0, 9);
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        a = 17'h1FFFF - 17'($urandom_range(0, 3));
      else
        a = 17'($urandom);
      nd = $urandom_range(0, 4);
      c = {1'b1, rd, 5'($urandom), a[16]};
      if (kind == 0) c[7] = 1'b0;
      fb.push_back(c);
      fb.push_back(a[15:8]);
      fb.push_back(a[7:0]);
      for (int k = 0; k < nd; k++) fb.push_back(8'($urandom));
      extra = 0;
      if (kind == 1) begin
        n = $urandom_range(0, fb.size() - 1);
        while (fb.size() > n) void'(fb.pop_back());
        extra = $urandom_range(1, 7);
      end
      do_frame(extra, $urandom_range(4, 7), $urandom_range(2, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
